// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the core's memory stage and a word-addressed
// 64-bit data memory. Byte-addressed RV64 loads are extracted and then sign-
// or zero-extended. Sub-doubleword stores use read-modify-write. Misaligned,
// illegal-width and out-of-range requests complete with resp_err and never
// reach the memory.
module lsu_mem_initiator #(
    parameter int XLEN         = 64,
    parameter int MEM_ADDRSIZE = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    // request side
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [XLEN-1:0]         req_addr,
    input  logic [XLEN-1:0]         req_wdata,
    // response side
    output logic                    resp_valid,
    output logic [XLEN-1:0]         resp_rdata,
    output logic                    resp_err,
    // memory port
    output logic                    mem_wren,
    output logic                    mem_rden,
    output logic [MEM_ADDRSIZE-1:0] mem_addr,
    output logic [63:0]             mem_d,
    input  logic [63:0]             mem_q
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t state_reg, state_next;

    // Latched request fields
    logic [2:0]              funct3_reg;
    logic [2:0]              off_reg;
    logic [63:0]             wdata_reg;
    logic [MEM_ADDRSIZE-1:0] mem_addr_reg;
    logic [63:0]             mem_d_reg;
    logic [XLEN-1:0]         resp_rdata_reg;
    logic                    resp_err_reg;

    // Accept-time decode of the incoming request
    logic [2:0] req_off;
    logic       acc_illegal;
    logic       acc_misaligned;
    logic       acc_range;
    logic       acc_err;
    logic       accept;

    assign req_off = req_addr[2:0];
    assign accept  = (state_reg == IDLE) && req_valid;

    // Classify the incoming request: illegal code, misalignment, out of range
    always_comb begin
        acc_illegal    = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        acc_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   acc_misaligned = req_off[0];
            2'b10:   acc_misaligned = (req_off[1:0] != 2'b00);
            2'b11:   acc_misaligned = (req_off != 3'b000);
            default: acc_misaligned = 1'b0;
        endcase
        acc_range = |req_addr[XLEN-1:MEM_ADDRSIZE+3];
        acc_err   = acc_illegal || acc_misaligned || acc_range;
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend
    logic [63:0] load_shifted;
    logic [63:0] load_ext;

    assign load_shifted = mem_q >> {off_reg, 3'b000};

    // Extend the shifted word according to the latched width code
    always_comb begin
        load_ext = '0;
        case (funct3_reg)
            3'b000:  load_ext = {{56{load_shifted[7]}},  load_shifted[7:0]};
            3'b001:  load_ext = {{48{load_shifted[15]}}, load_shifted[15:0]};
            3'b010:  load_ext = {{32{load_shifted[31]}}, load_shifted[31:0]};
            3'b011:  load_ext = load_shifted;
            3'b100:  load_ext = {56'd0, load_shifted[7:0]};
            3'b101:  load_ext = {48'd0, load_shifted[15:0]};
            3'b110:  load_ext = {32'd0, load_shifted[31:0]};
            default: load_ext = '0;
        endcase
    end

    // Store merge: lane mask for the access size, moved to the byte offset
    logic [7:0]  size_mask;
    logic [7:0]  byte_mask;
    logic [63:0] wdata_shifted;
    logic [63:0] merged;

    // Number of bytes touched by a store, as a contiguous low-order mask
    always_comb begin
        size_mask = 8'h00;
        case (funct3_reg[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign byte_mask     = size_mask << off_reg;
    assign wdata_shifted = wdata_reg << {off_reg, 3'b000};

    // Per-lane select between store data and the word read back
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign merged[8*gi+7:8*gi] = byte_mask[gi] ? wdata_shifted[8*gi+7:8*gi]
                                                       : mem_q[8*gi+7:8*gi];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; faults skip memory and go straight to the response
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (acc_err)
                        state_next = RESP;
                    else if (!req_we)
                        state_next = RD;
                    else if (req_funct3[1:0] == 2'b11)
                        state_next = WR;
                    else
                        state_next = RMW_RD;
                end
            end
            RD:      state_next = RESP;
            RMW_RD:  state_next = WR;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: latch on accept, capture read data, clear on return to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_reg     <= '0;
            off_reg        <= '0;
            wdata_reg      <= '0;
            mem_addr_reg   <= '0;
            mem_d_reg      <= '0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        funct3_reg <= req_funct3;
                        off_reg    <= req_off;
                        wdata_reg  <= req_wdata[63:0];
                        if (acc_err) begin
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= '0;
                        end else begin
                            // Only a real access moves the memory address
                            mem_addr_reg <= req_addr[MEM_ADDRSIZE+2:3];
                            if (req_we && (req_funct3[1:0] == 2'b11))
                                mem_d_reg <= req_wdata[63:0];
                        end
                    end
                end
                RD: begin
                    resp_rdata_reg <= XLEN'(load_ext);
                end
                RMW_RD: begin
                    mem_d_reg <= merged;
                end
                RESP: begin
                    resp_rdata_reg <= '0;
                    resp_err_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs; strobes are gated by reset so an aborted WR never commits
    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign mem_wren   = (state_reg == WR) && !rst;
    assign mem_rden   = ((state_reg == RD) || (state_reg == RMW_RD)) && !rst;
    assign mem_addr   = mem_addr_reg;
    assign mem_d      = mem_d_reg;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: directed requests push expected
// responses into a queue; a monitor compares every resp_valid against it.
module tb_lsu_mem_initiator;

    localparam int XLEN = 64;
    localparam int MAS  = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid, req_ready, req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr, req_wdata;
    logic            resp_valid, resp_err;
    logic [XLEN-1:0] resp_rdata;
    logic            mem_wren, mem_rden;
    logic [MAS-1:0]  mem_addr;
    logic [63:0]     mem_d, mem_q;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.XLEN(XLEN), .MEM_ADDRSIZE(MAS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
        .mem_d(mem_d), .mem_q(mem_q)
    );

    // Memory model: combinational read, write on posedge; preload via poke port
    logic [63:0]    mem [0:(1<<MAS)-1];
    logic           poke_en = 1'b0;
    logic [MAS-1:0] poke_addr = '0;
    logic [63:0]    poke_data = '0;
    assign mem_q = mem[mem_addr];
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (mem_wren) mem[mem_addr] <= mem_d;
    end

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          t0;
        string       name;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int wren_cnt = 0;
    int rden_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: strobe counters and scoreboard comparison on every response
    always @(negedge clk) begin
        if (mem_wren) wren_cnt++;
        if (mem_rden) rden_cnt++;
        if (!rst && resp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h err=%b expected no response",
                         resp_rdata, resp_err);
            end else begin
                mon_e = q.pop_front();
                check64({mon_e.name, "_rdata"}, resp_rdata, mon_e.rdata);
                check64({mon_e.name, "_err"}, 64'(resp_err), 64'(mon_e.err));
                check64({mon_e.name, "_lat"}, 64'(cyc - mon_e.t0), 64'(mon_e.lat));
                $display("resp %s: rdata=%h err=%b lat=%0d", mon_e.name, resp_rdata, resp_err,
                         cyc - mon_e.t0);
            end
        end
    end

    task automatic poke(input logic [MAS-1:0] a, input logic [63:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Present one request on the first cycle req_ready is high
    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_rdata, input logic exp_err,
                         input int exp_lat, output int waits);
        exp_t e;
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: got req_ready=0 expected 1 within 20 cycles", name);
            return;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.t0 = cyc; e.name = name;
        q.push_back(e);
        $display("req  %s: we=%b f3=%b addr=%h wdata=%h", name, we, f3, addr, wdata);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_resp_timeout: got %0d pending expected 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic run(input string name, input logic we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_rdata, input logic exp_err, input int exp_lat);
        int w;
        issue(name, we, f3, addr, wdata, exp_rdata, exp_err, exp_lat, w);
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w, w0, r0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check64("rst_ready",    64'(req_ready),  64'd1);
        check64("rst_valid",    64'(resp_valid), 64'd0);
        check64("rst_err",      64'(resp_err),   64'd0);
        check64("rst_rdata",    resp_rdata,      64'd0);
        check64("rst_mem_addr", 64'(mem_addr),   64'd0);
        check64("rst_mem_d",    mem_d,           64'd0);
        check64("rst_wren",     64'(mem_wren),   64'd0);
        check64("rst_rden",     64'(mem_rden),   64'd0);
        rst = 1'b0;
        @(negedge clk);

        poke(10'd2,    64'hA5A5_A5A5_A5A5_A5A5);
        poke(10'd3,    64'h1111_2222_3333_4444);
        poke(10'd4,    64'h5A5A_5A5A_5A5A_5A5A);
        poke(10'd5,    64'h8877_6655_4433_22F1);
        poke(10'd1023, 64'h0011_2233_4455_6677);

        // Loads: sign and zero extension at various offsets
        run("lb",  1'b0, 3'b000, 64'h28, 64'h0, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 2);
        run("lbu", 1'b0, 3'b100, 64'h28, 64'h0, 64'h0000_0000_0000_00F1, 1'b0, 2);
        run("lw",  1'b0, 3'b010, 64'h2C, 64'h0, 64'hFFFF_FFFF_8877_6655, 1'b0, 2);
        run("lwu", 1'b0, 3'b110, 64'h2C, 64'h0, 64'h0000_0000_8877_6655, 1'b0, 2);
        run("lh",  1'b0, 3'b001, 64'h2E, 64'h0, 64'hFFFF_FFFF_FFFF_8877, 1'b0, 2);
        run("lhu", 1'b0, 3'b101, 64'h2A, 64'h0, 64'h0000_0000_0000_4433, 1'b0, 2);
        run("ld",  1'b0, 3'b011, 64'h28, 64'h0, 64'h8877_6655_4433_22F1, 1'b0, 2);

        // Read-modify-write halfword store
        w0 = wren_cnt;
        run("sh", 1'b1, 3'b001, 64'h1A, 64'h0000_0000_0000_ABCD, 64'h0, 1'b0, 3);
        check64("sh_word3",  mem[3], 64'h1111_2222_ABCD_4444);
        check64("sh_word2",  mem[2], 64'hA5A5_A5A5_A5A5_A5A5);
        check64("sh_word4",  mem[4], 64'h5A5A_5A5A_5A5A_5A5A);
        check64("sh_wren_n", 64'(wren_cnt - w0), 64'd1);

        // SD followed immediately by LD of the same address
        issue("sd",   1'b1, 3'b011, 64'h40, 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0, 2, w);
        issue("ld_b", 1'b0, 3'b011, 64'h40, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0, 2, w);
        check64("b2b_busy_cycles", 64'(w), 64'd2);
        wait_done("ld_b");

        // Faults: no memory strobes at all
        w0 = wren_cnt; r0 = rden_cnt;
        run("f_lh_mis",  1'b0, 3'b001, 64'h3,    64'h0,  64'h0, 1'b1, 1);
        run("f_sw_mis",  1'b1, 3'b010, 64'h6,    64'h77, 64'h0, 1'b1, 1);
        run("f_ill111",  1'b0, 3'b111, 64'h0,    64'h0,  64'h0, 1'b1, 1);
        run("f_st100",   1'b1, 3'b100, 64'h0,    64'h0,  64'h0, 1'b1, 1);
        run("f_range",   1'b0, 3'b011, 64'h2000, 64'h0,  64'h0, 1'b1, 1);
        check64("fault_wren_n", 64'(wren_cnt - w0), 64'd0);
        check64("fault_rden_n", 64'(rden_cnt - r0), 64'd0);

        // Reset during the WR cycle of an SB to word 2
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 64'h10; req_wdata = 64'hEE;
        $display("req  sb_rst: we=1 f3=000 addr=%h wdata=%h", req_addr, req_wdata);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check64("rstwr_in_wr", 64'(mem_wren), 64'd1);
        rst = 1'b1;
        #1;
        check64("rstwr_gated", 64'(mem_wren), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check64("rstwr_ready", 64'(req_ready),  64'd1);
        check64("rstwr_novld", 64'(resp_valid), 64'd0);
        check64("rstwr_word2", mem[2], 64'hA5A5_A5A5_A5A5_A5A5);

        // Top byte of the top word
        run("sb_top",  1'b1, 3'b000, 64'h1FFF, 64'h5A, 64'h0, 1'b0, 3);
        check64("top_word", mem[1023], 64'h5A11_2233_4455_6677);
        run("lbu_top", 1'b0, 3'b100, 64'h1FFF, 64'h0, 64'h5A, 1'b0, 2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
